// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, read-only COUNT, reserved slot reads 0.
module timer_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [1:0] RegCtrl   = 2'b00;
  localparam logic [1:0] RegPreset = 2'b01;
  localparam logic [1:0] RegCount  = 2'b10;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic one_shot;
  logic ctrl_wr;

  // Only addr[3:2] selects a register; the rest of the word address is don't-care.
  logic unused_addr;
  assign unused_addr = ^addr[31:4];

  // MODE 01 is auto-reload; every other encoding behaves as one-shot.
  assign one_shot = (ctrl_q[2:1] != 2'b01);
  assign ctrl_wr  = we && (addr[3:2] == RegCtrl);

  // Register file writes and counter FSM next-state.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // Software writes; a one-shot interrupt is acknowledged by any CTRL write.
    if (ctrl_wr) begin
      ctrl_d = wdata[3:0];
      if (one_shot) irq_flag_d = 1'b0;
    end
    if (we && (addr[3:2] == RegPreset)) begin
      preset_d = wdata;
    end

    // FSM updates come after the write so an expiry in the same cycle is not lost.
    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0]) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_q[0]) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        state_d = StIdle;
        if (one_shot) begin
          // A simultaneous software CTRL write wins over the automatic EN clear.
          if (!ctrl_wr) ctrl_d[0] = 1'b0;
        end else begin
          irq_flag_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register storage with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational read mux for the addressed register.
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      RegCtrl:   rdata = {28'd0, ctrl_q};
      RegPreset: rdata = preset_q;
      RegCount:  rdata = count_q;
      default:   rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// mode/preset runs compared against closed-form timing predictions.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:2] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:2] ACtrl   = 30'h0;
  localparam logic [31:2] APreset = 30'h1;
  localparam logic [31:2] ACount  = 30'h2;
  localparam logic [31:2] ARsvd   = 30'h3;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; the write edge is the reference edge E0.
  task automatic wr(input logic [31:2] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:2] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // A preset of 0 runs like a preset of 1.
  function automatic int eff_of(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // Expected COUNT k edges after EN was written (count was 0 beforehand).
  // Load lands at k=2, then one decrement per edge down to 0; auto-reload
  // repeats the whole thing every eff+3 edges.
  function automatic logic [31:0] model_count(input int n, input bit is_auto, input int k);
    int j;
    j = k;
    if (is_auto) j = k % (eff_of(n) + 3);
    if (j < 2) return 32'd0;
    if (n > j - 2) return 32'(n - (j - 2));
    return 32'd0;
  endfunction

  // Expiry at k=eff+2: one-shot holds the flag, auto-reload pulses once per period.
  function automatic logic model_irq(input int n, input bit is_auto, input bit im, input int k);
    int e;
    e = eff_of(n);
    if (!im) return 1'b0;
    if (is_auto) return (k % (e + 3)) == e + 2;
    return k >= e + 2;
  endfunction

  task automatic run_seq(input int n, input logic [1:0] mode, input bit im, input int cycles,
                         output int pulses);
    logic [31:0] c;
    bit is_auto;
    is_auto = (mode == 2'b01);
    pulses  = 0;
    reset_dut();
    wr(APreset, 32'(n));
    wr(ACtrl, {28'd0, im, mode, 1'b1});
    for (int k = 1; k <= cycles; k++) begin
      tick();
      rd(ACount, c);
      check($sformatf("count n=%0d mode=%0d k=%0d", n, mode, k), c, model_count(n, is_auto, k));
      check($sformatf("irq n=%0d mode=%0d im=%0d k=%0d", n, mode, im, k), {31'd0, irq},
            {31'd0, model_irq(n, is_auto, im, k)});
      if (irq) pulses++;
    end
  endtask

  initial begin
    logic [31:0] c, c1, c2;
    int          pulses;
    bit          found;
    int          n;
    logic [1:0]  mode;
    bit          im;

    reset_n = 1'b0;
    addr    = '0;
    we      = 1'b0;
    wdata   = '0;
    #12;
    reset_n = 1'b1;
    tick();

    // Reset asserted mid-count clears everything immediately.
    wr(APreset, 32'd10);
    wr(ACtrl, 32'h9);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    rd(ACount, c);  check("rst_count", c, 32'd0);
    rd(ACtrl, c);   check("rst_ctrl", c, 32'd0);
    rd(APreset, c); check("rst_preset", c, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (14) tick();
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    rd(ACount, c); check("post_rst_count", c, 32'd0);

    // One-shot, IM=1, PRESET=5: held interrupt, EN self-clears, CTRL write acks.
    run_seq(5, 2'b00, 1'b1, 8, pulses);
    rd(ACtrl, c); check("oneshot_ctrl_en_clr", c, 32'h8);
    check("oneshot_irq_held", {31'd0, irq}, 32'd1);
    wr(ACtrl, 32'h8);
    check("oneshot_ack", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: one-cycle pulse every 6 edges.
    run_seq(3, 2'b01, 1'b1, 18, pulses);
    check("auto_pulses", 32'(pulses), 32'd3);
    rd(ACtrl, c); check("auto_en_kept", c, 32'hB);

    // Masked one-shot: flag set but irq stays low; CTRL write clears the flag.
    run_seq(2, 2'b00, 1'b0, 6, pulses);
    rd(ACtrl, c); check("mask_en_clr", c, 32'h0);
    wr(ACtrl, 32'h8);
    check("mask_flag_cleared", {31'd0, irq}, 32'd0);
    tick();
    check("mask_flag_cleared_2", {31'd0, irq}, 32'd0);

    // PRESET=0 behaves as 1: irq after E3.
    run_seq(0, 2'b00, 1'b1, 4, pulses);

    // Register access boundaries.
    reset_dut();
    wr(ACtrl, 32'hFFFF_FFFF);
    rd(ACtrl, c); check("ctrl_width", c, 32'hF);
    reset_dut();
    wr(APreset, 32'hA5A5_0003);
    wr(ARsvd, 32'hDEAD_BEEF);
    rd(ARsvd, c); check("rsvd_read", c, 32'd0);
    rd(30'h2000_0003, c); check("rsvd_high_addr", c, 32'd0);
    rd(30'h2000_0001, c); check("preset_alias", c, 32'hA5A5_0003);
    rd(ACtrl, c); check("rsvd_no_ctrl", c, 32'd0);

    // Disable mid-count; PRESET change during CNT waits for the next LOAD.
    reset_dut();
    wr(APreset, 32'd20);
    wr(ACtrl, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(ACount, c);
      if (c == 32'd12) begin
        found = 1'b1;
      end else if (c == 32'd16) begin
        wr(APreset, 32'd33);
        rd(ACount, c);
        check("preset_mid_cnt", c, 32'd15);
      end else begin
        tick();
      end
    end
    check("reach_12", {31'd0, found}, 32'd1);
    wr(ACtrl, 32'h8);
    tick();
    rd(ACount, c1);
    check("freeze_range", {31'd0, (c1 == 32'd11) || (c1 == 32'd12)}, 32'd1);
    repeat (3) tick();
    rd(ACount, c2); check("freeze_hold", c2, c1);
    wr(ACount, 32'h55);
    rd(ACount, c); check("count_ro", c, c1);
    check("disable_no_irq", {31'd0, irq}, 32'd0);
    wr(ACtrl, 32'h9);
    tick();
    tick();
    rd(ACount, c); check("reenable_reload", c, 32'd33);

    // Randomized mode/preset/mask runs over three periods.
    for (int it = 0; it < 8; it++) begin
      n    = int'($urandom_range(0, 7));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      run_seq(n, mode, im, 3 * (eff_of(n) + 3), pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
